// File: rtl/router_pkg.sv
// Shared types and sizing for the 4x4 router grant controller.
package router_pkg;

    localparam int N_PORTS = 4;
    localparam int ADDR_W  = $clog2(N_PORTS);

    typedef logic [ADDR_W-1:0] port_idx_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Round-robin successor; N_PORTS is a power of 2, so the natural wrap is the modulo.
    function automatic port_idx_t next_idx(input port_idx_t p);
        return p + port_idx_t'(1);
    endfunction

endpackage

// File: rtl/router_out_arb.sv
// One output port's arbiter: round-robin pick in IDLE, packet-long hold in BUSY.
module router_out_arb
    import router_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [N_PORTS-1:0] i_cand,      // inputs requesting this output
    input  logic [N_PORTS-1:0] i_req,       // raw requests, used to detect abort by the owner
    input  logic [N_PORTS-1:0] i_eop,       // end-of-packet pulses from all inputs
    output logic               o_busy,
    output port_idx_t          o_sel,
    output logic [N_PORTS-1:0] o_owner_oh
);

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    port_idx_t  r_owner;
    port_idx_t  w_owner_nxt;
    port_idx_t  r_ptr;
    port_idx_t  w_ptr_nxt;
    logic       w_found;
    port_idx_t  w_winner;
    logic       w_release;

    // Round-robin search starting at the priority pointer.
    always_comb begin
        port_idx_t v_idx;
        w_found  = 1'b0;
        w_winner = r_ptr;
        v_idx    = r_ptr;
        for (int k = 0; k < N_PORTS; k++) begin
            v_idx = r_ptr + port_idx_t'(k);
            if (!w_found && i_cand[v_idx]) begin
                w_found  = 1'b1;
                w_winner = v_idx;
            end else begin
                w_found  = w_found;
            end
        end
    end

    // Owner ends its packet with EOP or aborts by dropping its request.
    always_comb begin
        w_release = i_eop[r_owner] || !i_req[r_owner];
    end

    // State, owner and pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ARB_IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Next-state logic; owner is kept after release so o_sel holds its last value.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ARB_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ARB_BUSY;
                    w_owner_nxt = w_winner;
                end else begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            ARB_BUSY: begin
                if (w_release) begin
                    w_state_nxt = ARB_IDLE;
                    w_ptr_nxt   = next_idx(r_owner);
                end else begin
                    w_state_nxt = ARB_BUSY;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    // Outputs decoded purely from registers.
    always_comb begin
        o_busy     = (r_state == ARB_BUSY);
        o_sel      = r_owner;
        o_owner_oh = {N_PORTS{1'b0}};
        if (r_state == ARB_BUSY) begin
            o_owner_oh[r_owner] = 1'b1;
        end else begin
            o_owner_oh = {N_PORTS{1'b0}};
        end
    end

endmodule

// File: rtl/router_grant_ctrl.sv
// Grant controller: one round-robin arbiter per output, grants merged per input.
module router_grant_ctrl
    import router_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_PORTS-1:0]        i_req,
    input  logic [N_PORTS*ADDR_W-1:0] i_dst_addr,
    input  logic [N_PORTS-1:0]        i_eop,
    output logic [N_PORTS-1:0]        o_gnt,
    output logic [N_PORTS*ADDR_W-1:0] o_sel,
    output logic [N_PORTS-1:0]        o_busy
);

    logic [N_PORTS-1:0] w_cand     [N_PORTS];
    logic [N_PORTS-1:0] w_owner_oh [N_PORTS];

    // Destination decode: candidate vector per output.
    always_comb begin
        for (int j = 0; j < N_PORTS; j++) begin
            for (int i = 0; i < N_PORTS; i++) begin
                w_cand[j][i] = i_req[i] &&
                               (i_dst_addr[i*ADDR_W +: ADDR_W] == port_idx_t'(j));
            end
        end
    end

    for (genvar j = 0; j < N_PORTS; j++) begin : g_arb
        router_out_arb u_arb (
            .clk        (clk),
            .reset      (reset),
            .i_cand     (w_cand[j]),
            .i_req      (i_req),
            .i_eop      (i_eop),
            .o_busy     (o_busy[j]),
            .o_sel      (o_sel[j*ADDR_W +: ADDR_W]),
            .o_owner_oh (w_owner_oh[j])
        );
    end

    // Grant per input: OR of owner one-hots, all sourced from arbiter registers.
    always_comb begin
        o_gnt = {N_PORTS{1'b0}};
        for (int j = 0; j < N_PORTS; j++) begin
            o_gnt = o_gnt | w_owner_oh[j];
        end
    end

endmodule

// File: tb/tb_router_grant_ctrl.sv
// Directed self-checking bench for router_grant_ctrl.
module tb_router_grant_ctrl;

    logic       clk;
    logic       reset;
    logic [3:0] i_req;
    logic [7:0] i_dst_addr;
    logic [3:0] i_eop;
    logic [3:0] o_gnt;
    logic [7:0] o_sel;
    logic [3:0] o_busy;

    int n_cmp = 0;
    int n_err = 0;

    router_grant_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .i_req      (i_req),
        .i_dst_addr (i_dst_addr),
        .i_eop      (i_eop),
        .o_gnt      (o_gnt),
        .o_sel      (o_sel),
        .o_busy     (o_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are then stable for sampling and inputs may change.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dst(input logic [1:0] d0, input logic [1:0] d1,
                           input logic [1:0] d2, input logic [1:0] d3);
        i_dst_addr = {d3, d2, d1, d0};
    endtask

    function automatic logic [1:0] sel_of(input int j);
        return o_sel[j*2 +: 2];
    endfunction

    initial begin
        logic [2:0] order [5];
        order[0] = 3'd0; order[1] = 3'd1; order[2] = 3'd2; order[3] = 3'd3; order[4] = 3'd0;

        reset = 1'b1;
        i_req = 4'b0000;
        i_eop = 4'b0000;
        i_dst_addr = 8'h00;

        // 1. reset with random activity
        for (int c = 0; c < 3; c++) begin
            reset = 1'b1;
            i_req = 4'($urandom);
            i_eop = 4'($urandom);
            i_dst_addr = 8'($urandom);
            tick();
            chk_val("rst_gnt", 32'(o_gnt), 32'h0);
            chk_val("rst_busy", 32'(o_busy), 32'h0);
            chk_val("rst_sel", 32'(o_sel), 32'h0);
        end
        reset = 1'b0;
        i_req = 4'b0000;
        i_eop = 4'b0000;
        tick();

        // 2. single request 0 -> output 2
        set_dst(2'd2, 2'd0, 2'd0, 2'd0);
        i_req = 4'b0001;
        tick();
        chk_val("single_gnt", 32'(o_gnt), 32'h1);
        chk_val("single_busy", 32'(o_busy), 32'h4);
        chk_val("single_sel2", 32'(sel_of(2)), 32'h0);
        i_eop = 4'b0001;
        tick();
        i_eop = 4'b0000;
        i_req = 4'b0000;
        chk_val("single_rel_gnt", 32'(o_gnt), 32'h0);
        chk_val("single_rel_busy", 32'(o_busy), 32'h0);
        tick();

        // 3. contention on output 1, 4-cycle packets
        set_dst(2'd1, 2'd1, 2'd1, 2'd1);
        i_req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_val("cont_gnt", 32'(o_gnt), 32'(4'b0001 << order[k]));
            chk_val("cont_sel1", 32'(sel_of(1)), 32'(order[k]));
            for (int c = 0; c < 3; c++) begin
                tick();
                chk_val("cont_hold", 32'(o_gnt), 32'(4'b0001 << order[k]));
            end
            i_eop = 4'b0001 << order[k];
            tick();
            i_eop = 4'b0000;
            chk_val("cont_idle_gnt", 32'(o_gnt), 32'h0);
            chk_val("cont_idle_busy", 32'(o_busy), 32'h0);
        end
        i_req = 4'b0000;
        tick();
        tick();

        // 4. parallel: input i -> output 3-i
        set_dst(2'd3, 2'd2, 2'd1, 2'd0);
        i_req = 4'b1111;
        tick();
        chk_val("par_gnt", 32'(o_gnt), 32'hF);
        chk_val("par_busy", 32'(o_busy), 32'hF);
        chk_val("par_sel", 32'(o_sel), 32'h1B);

        // 5a. abort: input 2 (owner of output 1) drops its request
        i_req = 4'b1011;
        tick();
        chk_val("abort_gnt", 32'(o_gnt), 32'hB);
        chk_val("abort_busy", 32'(o_busy), 32'hD);
        i_req = 4'b0000;
        tick();
        chk_val("abort_all_rel", 32'(o_busy), 32'h0);
        // pointer of output 1 should now be 3
        set_dst(2'd1, 2'd1, 2'd1, 2'd1);
        i_req = 4'b1111;
        tick();
        chk_val("abort_ptr_gnt", 32'(o_gnt), 32'h8);
        chk_val("abort_ptr_sel", 32'(sel_of(1)), 32'h3);

        // 5b. reset while busy
        reset = 1'b1;
        tick();
        chk_val("midrst_gnt", 32'(o_gnt), 32'h0);
        chk_val("midrst_busy", 32'(o_busy), 32'h0);
        chk_val("midrst_sel", 32'(o_sel), 32'h0);
        reset = 1'b0;
        i_req = 4'b0000;
        tick();

        // 6. ignored events while input 1 owns output 0
        set_dst(2'd0, 2'd0, 2'd0, 2'd0);
        i_req = 4'b0010;
        tick();
        chk_val("ign_gnt", 32'(o_gnt), 32'h2);
        chk_val("ign_sel0", 32'(sel_of(0)), 32'h1);
        i_eop = 4'b1000;
        tick();
        i_eop = 4'b0000;
        chk_val("ign_eop_gnt", 32'(o_gnt), 32'h2);
        chk_val("ign_eop_busy", 32'(o_busy), 32'h1);
        set_dst(2'd0, 2'd3, 2'd0, 2'd0);
        tick();
        chk_val("ign_dst_sel0", 32'(sel_of(0)), 32'h1);
        chk_val("ign_dst_busy0", 32'(o_busy[0]), 32'h1);
        i_req = 4'b0000;
        tick();
        chk_val("ign_rel_busy", 32'(o_busy), 32'h0);
        chk_val("ign_rel_hold_sel0", 32'(sel_of(0)), 32'h1);
        chk_val("ign_rel_gnt", 32'(o_gnt), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
